// File: rtl/lcd1602_pkg.sv
// Shared types and constants for the LCD1602 responder: FSM states,
// instruction mask/match patterns and address-counter helpers.
package lcd1602_pkg;

  typedef enum logic [1:0] {
    S_CLEAR,
    S_IDLE,
    S_BUSY
  } lcd_state_t;

  typedef struct packed {
    logic [7:0] mask;
    logic [7:0] match;
  } cmd_pat_t;

  localparam cmd_pat_t CMD_DDRAM   = '{mask: 8'h80, match: 8'h80};
  localparam cmd_pat_t CMD_CGRAM   = '{mask: 8'hC0, match: 8'h40};
  localparam cmd_pat_t CMD_FUNC    = '{mask: 8'hE0, match: 8'h20};
  localparam cmd_pat_t CMD_SHIFT   = '{mask: 8'hF0, match: 8'h10};
  localparam cmd_pat_t CMD_DISPCTL = '{mask: 8'hF8, match: 8'h08};
  localparam cmd_pat_t CMD_ENTRY   = '{mask: 8'hFC, match: 8'h04};
  localparam cmd_pat_t CMD_HOME    = '{mask: 8'hFE, match: 8'h02};
  localparam cmd_pat_t CMD_CLEAR   = '{mask: 8'hFF, match: 8'h01};

  localparam logic [6:0] ROW1_BASE   = 7'h40;
  localparam logic [7:0] BLANK_CHAR  = 8'h20;
  localparam int         DDRAM_DEPTH = 32;

  function automatic logic cmd_is(input logic [7:0] db, input cmd_pat_t pat);
    return (db & pat.mask) == pat.match;
  endfunction

  function automatic logic [6:0] ac_mask(input logic [7:0] db);
    return {db[6], 2'b00, db[3:0]};
  endfunction

  function automatic logic [4:0] ddram_index(input logic [6:0] ac);
    return {ac[6], ac[3:0]};
  endfunction

  // AC only ever holds valid row addresses, so the column nibble alone decides wrapping
  function automatic logic [6:0] ac_step(input logic [6:0] ac, input logic inc);
    if (inc) begin
      if (ac[3:0] == 4'hF) return ac[6] ? 7'h00 : ROW1_BASE;
      return ac + 7'd1;
    end
    if (ac[3:0] == 4'h0) return ac[6] ? 7'h0F : (ROW1_BASE | 7'h0F);
    return ac - 7'd1;
  endfunction

endpackage

// File: rtl/lcd1602_responder_if.sv
// Controller-to-LCD parallel bus (E/RS/RW/DB plus read-back data and its tri-state enable).
interface lcd1602_responder_if;
  logic       lcd_e;
  logic       lcd_rs;
  logic       lcd_rw;
  logic [7:0] lcd_data_in;
  logic [7:0] lcd_data_out;
  logic       lcd_data_oe;

  modport master (
    output lcd_e, lcd_rs, lcd_rw, lcd_data_in,
    input  lcd_data_out, lcd_data_oe
  );

  modport slave (
    input  lcd_e, lcd_rs, lcd_rw, lcd_data_in,
    output lcd_data_out, lcd_data_oe
  );
endinterface

// File: rtl/lcd_bus_sync.sv
// Multi-stage synchronizer for the asynchronous LCD bus plus E edge detection.
// SYNC_STAGES must be at least 2.
module lcd_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clock_in,
  input  logic       reset_in,
  input  logic       pin_e,
  input  logic       pin_rs,
  input  logic       pin_rw,
  input  logic [7:0] pin_data,
  output logic       sync_e,
  output logic       sync_rs,
  output logic       sync_rw,
  output logic       e_rise,
  output logic       e_fall,
  output logic       cap_rs,
  output logic       cap_rw,
  output logic [7:0] cap_data
);

  logic [10:0] chain [SYNC_STAGES];
  logic [10:0] prev;

  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      for (int i = 0; i < SYNC_STAGES; i++) chain[i] <= '0;
      prev <= '0;
    end else begin
      chain[0] <= {pin_e, pin_rs, pin_rw, pin_data};
      for (int i = 1; i < SYNC_STAGES; i++) chain[i] <= chain[i-1];
      prev <= chain[SYNC_STAGES-1];
    end
  end

  assign sync_e  = chain[SYNC_STAGES-1][10];
  assign sync_rs = chain[SYNC_STAGES-1][9];
  assign sync_rw = chain[SYNC_STAGES-1][8];
  assign e_rise  = ~prev[10] & chain[SYNC_STAGES-1][10];
  assign e_fall  = prev[10] & ~chain[SYNC_STAGES-1][10];

  // prev is the last E-high sample, so its RS/RW/DB are the values latched by the fall
  assign cap_rs   = prev[9];
  assign cap_rw   = prev[8];
  assign cap_data = prev[7:0];

endmodule

// File: rtl/lcd1602_responder.sv
// HD44780-style 16x2 LCD device model: decodes the controller bus into a 32-entry DDRAM.
// Define LCD1602_READ_EN to enable busy-flag/AC and DDRAM reads over the bus.
module lcd1602_responder
  import lcd1602_pkg::*;
#(
  parameter int BUSY_CYCLES = 40,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clock_in,
  input  logic               reset_in,
  lcd1602_responder_if.slave bus,
  input  logic [4:0]         scan_addr,
  output logic [7:0]         scan_char,
  output logic               busy,
  output logic               display_on,
  output logic               cursor_on,
  output logic               blink_on,
  output logic               two_line,
  output logic [6:0]         addr_counter,
  output logic               cmd_dropped
);

  localparam int CNT_W = (BUSY_CYCLES > 1) ? $clog2(BUSY_CYCLES) : 1;
  localparam logic [CNT_W-1:0] BUSY_LOAD = CNT_W'(BUSY_CYCLES - 1);

  logic       sync_e, sync_rs, sync_rw, e_rise, e_fall;
  logic       cap_rs, cap_rw;
  logic [7:0] cap_data;

  lcd_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clock_in (clock_in),
    .reset_in (reset_in),
    .pin_e    (bus.lcd_e),
    .pin_rs   (bus.lcd_rs),
    .pin_rw   (bus.lcd_rw),
    .pin_data (bus.lcd_data_in),
    .sync_e   (sync_e),
    .sync_rs  (sync_rs),
    .sync_rw  (sync_rw),
    .e_rise   (e_rise),
    .e_fall   (e_fall),
    .cap_rs   (cap_rs),
    .cap_rw   (cap_rw),
    .cap_data (cap_data)
  );

  lcd_state_t     state;
  logic [4:0]     clear_idx;
  logic [CNT_W-1:0] busy_cnt;
  logic           entry_inc;
  logic [7:0]     ddram [DDRAM_DEPTH];

  logic           accept;
  logic           drop;
  logic           mem_we;
  logic [4:0]     mem_waddr;
  logic [7:0]     mem_wdata;

`ifdef LCD1602_READ_EN
  logic       rd_data;
  logic       rd_start_busy;
  logic       oe_q;
  logic [7:0] dout_q;

  // A data read that began while busy stays dropped even if busy clears before E falls
  assign rd_data = e_fall & cap_rw & cap_rs;
  assign accept  = (e_fall & ~cap_rw & ~busy) | (rd_data & ~busy & ~rd_start_busy);
  assign drop    = (e_fall & ~cap_rw & busy) | (rd_data & (busy | rd_start_busy));

  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      rd_start_busy <= 1'b0;
      oe_q          <= 1'b0;
      dout_q        <= 8'h00;
    end else begin
      if (e_rise) rd_start_busy <= busy;
      oe_q <= sync_e & sync_rw;
      if (sync_e & sync_rw)
        dout_q <= sync_rs ? ddram[ddram_index(addr_counter)] : {busy, addr_counter};
      else
        dout_q <= 8'h00;
    end
  end

  assign bus.lcd_data_oe  = oe_q;
  assign bus.lcd_data_out = dout_q;
`else
  logic unused_sync;

  assign accept           = e_fall & ~cap_rw & ~busy;
  assign drop             = e_fall & ~cap_rw & busy;
  assign bus.lcd_data_oe  = 1'b0;
  assign bus.lcd_data_out = 8'h00;
  assign unused_sync      = ^{e_rise, sync_e, sync_rs, sync_rw};
`endif

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = clear_idx;
    mem_wdata = BLANK_CHAR;
    if (!reset_in) begin
      if (state == S_CLEAR) begin
        mem_we = 1'b1;
      end else if (state == S_IDLE && accept && !cap_rw && cap_rs) begin
        mem_we    = 1'b1;
        mem_waddr = ddram_index(addr_counter);
        mem_wdata = cap_data;
      end
    end
  end

  // DDRAM has no reset; the clear walk that follows reset initialises it
  always_ff @(posedge clock_in) begin
    if (mem_we) ddram[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge clock_in) begin
    if (reset_in) scan_char <= 8'h00;
    else          scan_char <= ddram[scan_addr];
  end

  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      state        <= S_CLEAR;
      clear_idx    <= 5'd0;
      busy_cnt     <= '0;
      busy         <= 1'b1;
      addr_counter <= 7'h00;
      entry_inc    <= 1'b1;
      display_on   <= 1'b0;
      cursor_on    <= 1'b0;
      blink_on     <= 1'b0;
      two_line     <= 1'b0;
      cmd_dropped  <= 1'b0;
    end else begin
      cmd_dropped <= drop;
      case (state)
        S_CLEAR: begin
          busy         <= 1'b1;
          addr_counter <= 7'h00;
          entry_inc    <= 1'b1;
          clear_idx    <= clear_idx + 5'd1;
          if (clear_idx == 5'(DDRAM_DEPTH - 1)) begin
            state    <= S_BUSY;
            busy_cnt <= BUSY_LOAD;
          end
        end
        S_BUSY: begin
          if (busy_cnt == '0) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            busy_cnt <= busy_cnt - 1'b1;
          end
        end
        S_IDLE: begin
          if (accept) begin
            state    <= S_BUSY;
            busy     <= 1'b1;
            busy_cnt <= BUSY_LOAD;
            if (cap_rw || cap_rs) begin
              addr_counter <= ac_step(addr_counter, entry_inc);
            end else if (cmd_is(cap_data, CMD_DDRAM)) begin
              addr_counter <= ac_mask(cap_data);
            end else if (cmd_is(cap_data, CMD_CGRAM)) begin
              addr_counter <= addr_counter;
            end else if (cmd_is(cap_data, CMD_FUNC)) begin
              two_line <= cap_data[3];
            end else if (cmd_is(cap_data, CMD_SHIFT)) begin
              if (!cap_data[3]) addr_counter <= ac_step(addr_counter, cap_data[2]);
            end else if (cmd_is(cap_data, CMD_DISPCTL)) begin
              display_on <= cap_data[2];
              cursor_on  <= cap_data[1];
              blink_on   <= cap_data[0];
            end else if (cmd_is(cap_data, CMD_ENTRY)) begin
              entry_inc <= cap_data[1];
            end else if (cmd_is(cap_data, CMD_HOME)) begin
              addr_counter <= 7'h00;
            end else if (cmd_is(cap_data, CMD_CLEAR)) begin
              state     <= S_CLEAR;
              clear_idx <= 5'd0;
            end
          end
        end
        default: begin
          state     <= S_CLEAR;
          clear_idx <= 5'd0;
          busy      <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd1602_responder.sv
// Scoreboard testbench for lcd1602_responder; expected DDRAM contents come from a bench model.
module tb_lcd1602_responder;

  localparam int BUSY_CYCLES = 40;
  localparam int SYNC_STAGES = 2;

  logic       clock_in = 1'b0;
  logic       reset_in = 1'b1;
  logic [4:0] scan_addr = 5'd0;
  logic [7:0] scan_char;
  logic       busy, display_on, cursor_on, blink_on, two_line, cmd_dropped;
  logic [6:0] addr_counter;

  lcd1602_responder_if bus ();

  lcd1602_responder #(
    .BUSY_CYCLES(BUSY_CYCLES),
    .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clock_in     (clock_in),
    .reset_in     (reset_in),
    .bus          (bus),
    .scan_addr    (scan_addr),
    .scan_char    (scan_char),
    .busy         (busy),
    .display_on   (display_on),
    .cursor_on    (cursor_on),
    .blink_on     (blink_on),
    .two_line     (two_line),
    .addr_counter (addr_counter),
    .cmd_dropped  (cmd_dropped)
  );

  always #5 clock_in = ~clock_in;

  int checks = 0;
  int errors = 0;
  int drop_count = 0;

  logic [7:0] model_ddram [32];
  logic [6:0] model_ac;
  logic       model_id;
  logic [7:0] exp_q [$];

  always @(negedge clock_in) if (cmd_dropped === 1'b1) drop_count++;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time exceeded");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [6:0] model_step(input logic [6:0] ac, input logic inc);
    logic [4:0] pos;
    pos = {ac[6], ac[3:0]};
    pos = inc ? pos + 5'd1 : pos - 5'd1;
    return {pos[4], 2'b00, pos[3:0]};
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) model_ddram[i] = 8'h20;
    model_ac = 7'h00;
    model_id = 1'b1;
  endtask

  task automatic bus_access(input logic rs, input logic rw, input logic [7:0] d);
    @(negedge clock_in);
    bus.lcd_rs = rs;
    bus.lcd_rw = rw;
    bus.lcd_data_in = d;
    @(negedge clock_in);
    bus.lcd_e = 1'b1;
    repeat (3) @(negedge clock_in);
    bus.lcd_e = 1'b0;
    repeat (2) @(negedge clock_in);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    repeat (4) @(posedge clock_in);
    #1;
    while (busy !== 1'b0 && n < 500) begin
      @(posedge clock_in);
      #1;
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s idle_timeout: busy=%b required 0", tag, busy);
    end
  endtask

  task automatic send_cmd(input logic [7:0] d);
    bus_access(1'b0, 1'b0, d);
    casez (d)
      8'b1???????: model_ac = {d[6], 2'b00, d[3:0]};
      8'b01??????: ;
      8'b001?????: ;
      8'b0001????: if (!d[3]) model_ac = model_step(model_ac, d[2]);
      8'b00001???: ;
      8'b000001??: model_id = d[1];
      8'b0000001?: model_ac = 7'h00;
      8'b00000001: model_clear();
      default: ;
    endcase
    wait_idle("cmd");
  endtask

  task automatic send_data(input logic [7:0] d);
    bus_access(1'b1, 1'b0, d);
    model_ddram[{model_ac[6], model_ac[3:0]}] = d;
    model_ac = model_step(model_ac, model_id);
    wait_idle("data");
  endtask

  task automatic scan_check(input string tag);
    logic [7:0] exp;
    for (int i = 0; i < 32; i++) begin
      @(negedge clock_in);
      scan_addr = 5'(i);
      exp_q.push_back(model_ddram[i]);
      @(posedge clock_in);
      #1;
      exp = exp_q.pop_front();
      checks++;
      if (scan_char !== exp) begin
        errors++;
        $display("[TB] FAIL %s scan[%0d]: got %h required %h", tag, i, scan_char, exp);
      end
    end
  endtask

  task automatic check_ac(input string tag, input logic [6:0] exp);
    checks++;
    if (addr_counter !== exp) begin
      errors++;
      $display("[TB] FAIL %s ac: got %h required %h", tag, addr_counter, exp);
    end
  endtask

  task automatic measure_clear(input string tag);
    int n;
    n = 0;
    do begin
      @(posedge clock_in);
      #1;
      n++;
    end while (busy !== 1'b0 && n < 500);
    checks++;
    if (n != 32 + BUSY_CYCLES) begin
      errors++;
      $display("[TB] FAIL %s busy_len: got %0d required %0d", tag, n, 32 + BUSY_CYCLES);
    end
  endtask

  task automatic test_reset();
    reset_in = 1'b1;
    repeat (3) @(posedge clock_in);
    #1;
    checks++;
    if ({busy, display_on, cursor_on, blink_on, two_line, cmd_dropped} !== 6'b100000) begin
      errors++;
      $display("[TB] FAIL reset flags: got %b required 100000",
               {busy, display_on, cursor_on, blink_on, two_line, cmd_dropped});
    end
    checks++;
    if (bus.lcd_data_oe !== 1'b0 || bus.lcd_data_out !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset bus_out: got oe=%b data=%h required 0/00",
               bus.lcd_data_oe, bus.lcd_data_out);
    end
    checks++;
    if (scan_char !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset scan_char: got %h required 00", scan_char);
    end
    check_ac("reset", 7'h00);
    @(negedge clock_in);
    reset_in = 1'b0;
    measure_clear("reset");
    model_clear();
    scan_check("reset");
  endtask

  task automatic test_basic_writes();
    send_cmd(8'h01);
    send_cmd(8'h38);
    send_cmd(8'h06);
    send_cmd(8'h0C);
    send_cmd(8'h81);
    send_data(8'h41);
    send_data(8'h42);
    scan_check("basic");
    check_ac("basic", 7'h03);
    checks++;
    if ({display_on, cursor_on, blink_on, two_line} !== 4'b1001) begin
      errors++;
      $display("[TB] FAIL basic dispctl: got %b required 1001",
               {display_on, cursor_on, blink_on, two_line});
    end
    checks++;
    if (drop_count != 0) begin
      errors++;
      $display("[TB] FAIL basic drops: got %0d required 0", drop_count);
    end
  endtask

  task automatic test_row_wrap();
    send_cmd(8'h8F);
    send_data(8'h58);
    send_data(8'h59);
    check_ac("wrap_inc", 7'h41);
    checks++;
    if (model_ddram[15] !== 8'h58 || model_ddram[16] !== 8'h59) begin
      errors++;
      $display("[TB] FAIL wrap_inc model: got %h/%h required 58/59", model_ddram[15], model_ddram[16]);
    end
    scan_check("wrap_inc");
    send_cmd(8'h04);
    send_cmd(8'hC0);
    send_data(8'h5A);
    send_data(8'h5B);
    check_ac("wrap_dec", 7'h0E);
    scan_check("wrap_dec");
  endtask

  task automatic test_drop();
    int d0;
    d0 = drop_count;
    bus_access(1'b0, 1'b0, 8'h80);
    model_ac = 7'h00;
    bus_access(1'b1, 1'b0, 8'h48);
    wait_idle("drop");
    checks++;
    if (drop_count - d0 != 1) begin
      errors++;
      $display("[TB] FAIL drop pulses: got %0d required 1", drop_count - d0);
    end
    check_ac("drop", 7'h00);
    scan_check("drop");
  endtask

  task automatic test_reset_mid_clear();
    int n;
    bus_access(1'b0, 1'b0, 8'h01);
    n = 0;
    while (busy !== 1'b1 && n < 50) begin
      @(negedge clock_in);
      n++;
    end
    repeat (10) @(negedge clock_in);
    reset_in = 1'b1;
    @(negedge clock_in);
    reset_in = 1'b0;
    measure_clear("midclr");
    model_clear();
    scan_check("midclr");
    check_ac("midclr", 7'h00);
    checks++;
    if ({display_on, two_line} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL midclr flags: got %b required 00", {display_on, two_line});
    end
  endtask

`ifdef LCD1602_READ_EN
  task automatic test_read();
    int d0;
    send_cmd(8'h85);
    send_data(8'h77);
    send_cmd(8'h85);
    d0 = drop_count;
    @(negedge clock_in);
    bus.lcd_rs = 1'b0;
    bus.lcd_rw = 1'b1;
    bus.lcd_data_in = 8'h00;
    @(negedge clock_in);
    bus.lcd_e = 1'b1;
    repeat (5) @(negedge clock_in);
    checks++;
    if (bus.lcd_data_oe !== 1'b1 || bus.lcd_data_out !== 8'h05) begin
      errors++;
      $display("[TB] FAIL read_status: got oe=%b data=%h required 1/05",
               bus.lcd_data_oe, bus.lcd_data_out);
    end
    bus.lcd_e = 1'b0;
    repeat (6) @(negedge clock_in);
    check_ac("read_status", 7'h05);
    checks++;
    if (busy !== 1'b0 || drop_count != d0) begin
      errors++;
      $display("[TB] FAIL read_status side_effect: got busy=%b drops=%0d required 0/0",
               busy, drop_count - d0);
    end
    @(negedge clock_in);
    bus.lcd_rs = 1'b1;
    @(negedge clock_in);
    bus.lcd_e = 1'b1;
    repeat (5) @(negedge clock_in);
    checks++;
    if (bus.lcd_data_oe !== 1'b1 || bus.lcd_data_out !== model_ddram[5]) begin
      errors++;
      $display("[TB] FAIL read_data: got oe=%b data=%h required 1/%h",
               bus.lcd_data_oe, bus.lcd_data_out, model_ddram[5]);
    end
    bus.lcd_e = 1'b0;
    repeat (2) @(negedge clock_in);
    model_ac = model_step(model_ac, model_id);
    wait_idle("read_data");
    check_ac("read_data", 7'h06);
    checks++;
    if (bus.lcd_data_oe !== 1'b0) begin
      errors++;
      $display("[TB] FAIL read_data oe_release: got %b required 0", bus.lcd_data_oe);
    end
    bus.lcd_rw = 1'b0;
  endtask
`else
  task automatic test_read();
    int d0;
    send_cmd(8'h85);
    d0 = drop_count;
    @(negedge clock_in);
    bus.lcd_rs = 1'b1;
    bus.lcd_rw = 1'b1;
    @(negedge clock_in);
    bus.lcd_e = 1'b1;
    repeat (5) @(negedge clock_in);
    checks++;
    if (bus.lcd_data_oe !== 1'b0 || bus.lcd_data_out !== 8'h00) begin
      errors++;
      $display("[TB] FAIL read_ignored bus: got oe=%b data=%h required 0/00",
               bus.lcd_data_oe, bus.lcd_data_out);
    end
    bus.lcd_e = 1'b0;
    repeat (8) @(negedge clock_in);
    check_ac("read_ignored", 7'h05);
    checks++;
    if (busy !== 1'b0 || drop_count != d0) begin
      errors++;
      $display("[TB] FAIL read_ignored side_effect: got busy=%b drops=%0d required 0/0",
               busy, drop_count - d0);
    end
    bus.lcd_rw = 1'b0;
  endtask
`endif

  initial begin
    bus.lcd_e = 1'b0;
    bus.lcd_rs = 1'b0;
    bus.lcd_rw = 1'b0;
    bus.lcd_data_in = 8'h00;
    model_clear();
    test_reset();
    test_basic_writes();
    test_row_wrap();
    test_drop();
    test_reset_mid_clear();
    test_read();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lcd1602_responder.md
Name: lcd1602_responder

Overview:
- Device-side model of the 16x2 HD44780-style character LCD. It is the responder for the team's LCD1602 write controller.
- Samples the controller's E/RS/RW/DB bus and decodes instructions and data into a 32-character DDRAM.
- Maintains the address counter (AC), busy flag and display-control state.
- Exposes a scan port for a video/VGA overlay or for bench checking. Used for FPGA emulation and self-checking of the controller.

Parameters:
- BUSY_CYCLES, 40, clock cycles busy after each accepted instruction or data write.
- SYNC_STAGES, 2, synchronizer depth on lcd_e/lcd_rs/lcd_rw/lcd_data_in (min 2).

Ports:
- clock_in  in  1  system clock
- reset_in  in  1  synchronous, active-high reset
- lcd_e  in  1  enable from controller
- lcd_rs  in  1  0 instruction, 1 data
- lcd_rw  in  1  0 write, 1 read
- lcd_data_in  in  8  DB[7:0] from controller
- lcd_data_out  out  8  DB[7:0] driven on reads
- lcd_data_oe  out  1  tri-state enable for DB
- scan_addr  in  5  {row, col[3:0]}
- scan_char  out  8  DDRAM[scan_addr], 1-cycle registered latency
- busy  out  1  busy flag
- display_on, cursor_on, blink_on  out  1 each  display-control bits D/C/B
- two_line  out  1  function-set N bit
- addr_counter  out  7  current AC
- cmd_dropped  out  1  1-cycle pulse when an access arrives while busy

Behaviour:
- All bus inputs pass through SYNC_STAGES flops. E falling edge = synced E 1 then 0. RS/RW/DB are taken from the synced stage co-timed with the last E-high sample.
- A write takes effect SYNC_STAGES+1 cycles after the E fall at the pin. scan_char reflects it one cycle later.
- FSM states: S_CLEAR, S_IDLE, S_BUSY.
- S_CLEAR: walks 32 entries writing 0x20 (one per cycle), sets AC=0 and I/D=1, busy=1. Then goes to S_BUSY with a BUSY_CYCLES countdown.
- S_BUSY: busy=1. The countdown reaches 0, then the FSM returns to S_IDLE.
- S_IDLE: busy=0. An E fall with RW=0 executes and enters S_BUSY (or S_CLEAR on a clear instruction).
- Reset values: state=S_CLEAR (DDRAM cleared after reset), AC=0, I/D=1, display_on=cursor_on=blink_on=0, two_line=0, lcd_data_oe=0, lcd_data_out=0, cmd_dropped=0. scan_char=0 until the first scan read.
- Reset asserted mid-clear or mid-busy restarts S_CLEAR from entry 0.
- Instruction decode (RS=0, RW=0), first match from MSB:
  - 1aaaaaaa: AC=a.
  - 01xxxxxx: CGRAM address; accepted, no effect.
  - 001DNFxx: two_line=N; DL and F ignored.
  - 0001SRxx: if S=0, AC moves +1 (R=1) or -1 (R=0) with wrap. If S=1, display shift; no-op.
  - 00001DCB: display_on/cursor_on/blink_on.
  - 000001IS: I/D=I; S ignored.
  - 0000001x: AC=0.
  - 00000001: clear.
  - 0x00: no-op, still busy.
- Data write (RS=1, RW=0): DDRAM[{AC[6],AC[3:0]}]=DB, then AC steps per I/D.
- Address map:
  - Valid AC values are 0x00-0x0F and 0x40-0x4F.
  - Set-address values outside these ranges are stored masked to {a[6],2'b00,a[3:0]}.
  - Increment wraps 0x0F->0x40 and 0x4F->0x00. Decrement wraps 0x00->0x4F and 0x40->0x0F.
- Any E fall while busy=1 is dropped, with no state change, and cmd_dropped pulses once.
- A scan read of an address written in the same cycle returns the old value.

Optional Feature:
- Macro LCD1602_READ_EN.
- Defined:
  - While synced E=1 and RW=1, lcd_data_oe=1.
  - RS=0: lcd_data_out={busy, AC}, valid even while busy.
  - RS=1: lcd_data_out=DDRAM[AC]. On that access's E fall, AC steps per I/D and the block enters S_BUSY. The read is dropped, with cmd_dropped pulsing, if it starts while busy.
- Undefined: lcd_data_oe=0, lcd_data_out=0, and RW=1 accesses are ignored entirely (no AC change, no pulse).

Decomposition:
- lcd1602_pkg holds:
  - the FSM state enum;
  - instruction mask/match constants (CMD_CLEAR, CMD_HOME, CMD_ENTRY, CMD_DISPCTL, CMD_SHIFT, CMD_FUNC, CMD_CGRAM, CMD_DDRAM);
  - ROW1_BASE=7'h40, BLANK_CHAR=8'h20, DDRAM_DEPTH=32.
- One sub-module, lcd_bus_sync: the SYNC_STAGES synchronizer plus E rise/fall detect.

Test Plan:
- Reset, then wait for busy=0 -> all 32 scan_char=0x20, busy high for 32+BUSY_CYCLES cycles.
- Write 01,38,06,0C,81, then data 0x41,0x42, each after busy=0 -> scan[1]=0x41, scan[2]=0x42, AC=0x03, display_on=1, cursor_on=0, blink_on=0, two_line=1.
- Write 0x8F then 0x58,0x59 -> scan[15]=0x58, scan[16]=0x59, AC=0x41. Then 0x04, 0xC0, 0x5A,0x5B -> scan[16]=0x5A, scan[15]=0x5B, AC=0x0E.
- Send 0x48 one cycle after a preceding write's E-fall detect -> cmd_dropped pulses once, DDRAM unchanged.
- Assert reset_in 10 cycles into a clear -> restarts from entry 0, all 0x20 afterwards, AC=0.
- With LCD1602_READ_EN, after 0x85: RS=0 RW=1 read while idle -> lcd_data_out=8'h05, oe=1. RS=1 read -> DDRAM[5], AC=0x06.
